// File: rtl/dbus_sram_responder.sv
// Data-bus responder backed by a single-ported 64-bit SRAM model with a fixed programmable latency.
// Optional alignment checking is enabled by defining DBUS_RESP_MISALIGN_CHECK_EN.

package dbus_pkg;
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_sram_responder
    import dbus_pkg::*;
#(
    parameter int unsigned DEPTH   = 4096,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       busy,
    output logic       err
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = 4;
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d;
    msize_t      size_q, size_d;
    logic [7:0]  strobe_q, strobe_d;
    logic [63:0] wdata_q, wdata_d;
    dbus_resp_t  resp_q, resp_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic [63:0] mem [DEPTH];

    // Request seen by the array: live bus in IDLE (only reaches RESP from IDLE when LATENCY=1), else the latch
    logic [63:0] src_addr_c;
    logic [7:0]  src_strobe_c;
    logic [63:0] src_wdata_c;
    logic [63:0] off_c;
    logic [AW-1:0] idx_c;
    logic        in_range_c;
    logic        misalign_c;
    logic        access_ok_c;
    logic        mem_we_c;

    always_comb begin
        src_addr_c   = (state_q == IDLE) ? dreq.addr   : addr_q;
        src_strobe_c = (state_q == IDLE) ? dreq.strobe : strobe_q;
        src_wdata_c  = (state_q == IDLE) ? dreq.data   : wdata_q;
        off_c        = src_addr_c - BASE;
        idx_c        = off_c[AW+2:3];
        in_range_c   = (src_addr_c >= BASE) && (off_c < SPAN);
    end

`ifdef DBUS_RESP_MISALIGN_CHECK_EN
    msize_t     src_size_c;
    logic [2:0] align_mask_c;

    always_comb begin
        src_size_c = (state_q == IDLE) ? dreq.size : size_q;
        case (src_size_c)
            MSIZE1:  align_mask_c = 3'b000;
            MSIZE2:  align_mask_c = 3'b001;
            MSIZE4:  align_mask_c = 3'b011;
            default: align_mask_c = 3'b111;
        endcase
        misalign_c = |(src_addr_c[2:0] & align_mask_c);
    end
`else
    logic unused_size;

    assign misalign_c  = 1'b0;
    assign unused_size = ^size_q;
`endif

    assign access_ok_c = in_range_c && !misalign_c;

    // Next-state, request latch and registered response
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        size_d   = size_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        resp_d   = '0;
        err_d    = 1'b0;
        mem_we_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (dreq.valid) begin
                    addr_d   = dreq.addr;
                    size_d   = dreq.size;
                    strobe_d = dreq.strobe;
                    wdata_d  = dreq.data;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if ((state_d == RESP) && (state_q != RESP)) begin
            resp_d.addr_ok = 1'b1;
            resp_d.data_ok = 1'b1;
            err_d          = !access_ok_c;
            if ((src_strobe_c == 8'h00) && access_ok_c) begin
                resp_d.data = mem[idx_c];
            end
            mem_we_c = (src_strobe_c != 8'h00) && access_ok_c;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            size_q   <= MSIZE1;
            strobe_q <= '0;
            wdata_q  <= '0;
            resp_q   <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
            resp_q   <= resp_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    // Array contents survive reset; a write only lands on the edge that enters RESP
    always_ff @(posedge clk) begin
        if (mem_we_c && !reset) begin
            for (int i = 0; i < 8; i++) begin
                if (src_strobe_c[i]) begin
                    mem[idx_c][8*i +: 8] <= src_wdata_c[8*i +: 8];
                end
            end
        end
    end

    assign dresp = resp_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: directed steps plus random traffic against a byte-addressed memory model.
// Alignment expectations follow DBUS_RESP_MISALIGN_CHECK_EN when it is defined.

module tb_dbus_sram_responder;
    import dbus_pkg::*;

    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4096;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam logic [63:0] TOP   = BASE + 64'(DEPTH) * 64'd8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Reference memory: one entry per byte address
    byte unsigned mem_b [logic [63:0]];

    dbus_sram_responder #(
        .DEPTH   (DEPTH),
        .BASE    (BASE),
        .LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .dreq  (dreq),
        .dresp (dresp),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [63:0] a);
        return (a >= BASE) && (a < TOP);
    endfunction

    function automatic bit misaligned(input logic [63:0] a, input logic [2:0] sz);
`ifdef DBUS_RESP_MISALIGN_CHECK_EN
        logic [63:0] nbytes;
        nbytes = (sz > 3'd3) ? 64'd8 : (64'd1 << sz);
        return (a % nbytes) != 64'd0;
`else
        return (a == 64'd0) && (sz == 3'd7) && 1'b0;
`endif
    endfunction

    function automatic logic [63:0] model_read(input logic [63:0] a);
        logic [63:0] w;
        logic [63:0] r;
        w = a & ~64'h7;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (mem_b.exists(w + 64'(i))) r[8*i +: 8] = mem_b[w + 64'(i)];
        end
        return r;
    endfunction

    // One full transaction: drive, scramble the bus while busy, check timing, data and err
    task automatic txn(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] st,
                       input logic [63:0] d, input string tag, output logic [63:0] rdata);
        logic [63:0] exp_data;
        bit          ok;
        int          pulses;
        ok       = in_range(a) && !misaligned(a, sz);
        exp_data = ((st == 8'h00) && ok) ? model_read(a) : 64'h0;
        if ((st != 8'h00) && ok) begin
            for (int i = 0; i < 8; i++) begin
                if (st[i]) mem_b[(a & ~64'h7) + 64'(i)] = d[8*i +: 8];
            end
        end
        rdata  = '0;
        pulses = 0;
        @(negedge clk);
        dreq.valid  = 1'b1;
        dreq.addr   = a;
        dreq.size   = msize_t'(sz);
        dreq.strobe = st;
        dreq.data   = d;
        for (int k = 1; k <= int'(LAT) + 1; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                dreq.valid = 1'b0;
                dreq.addr  = a ^ 64'h40;
            end else if (k <= int'(LAT)) begin
                dreq.valid  = 1'($urandom);
                dreq.addr   = {$urandom, $urandom};
                dreq.strobe = 8'($urandom);
                dreq.data   = {$urandom, $urandom};
            end else begin
                dreq = '0;
            end
            @(negedge clk);
            if (dresp.data_ok === 1'b1) pulses++;
            chk({tag, ":busy"}, 64'(busy), 64'(k <= int'(LAT)));
            chk({tag, ":data_ok"}, 64'(dresp.data_ok), 64'(k == int'(LAT)));
            if (k == int'(LAT)) begin
                chk({tag, ":addr_ok"}, 64'(dresp.addr_ok), 64'd1);
                chk({tag, ":data"}, dresp.data, exp_data);
                chk({tag, ":err"}, 64'(err), 64'(!ok));
                rdata = dresp.data;
            end else begin
                chk({tag, ":err_idle"}, 64'(err), 64'd0);
            end
        end
        chk({tag, ":pulses"}, 64'(pulses), 64'd1);
    endtask

    initial begin
        logic [63:0] rd;
        logic [63:0] pre;
        logic [63:0] a;
        logic [7:0]  st;

        dreq = '0;
        #2 reset = 1'b1;
        #1;
        chk("rst:busy", 64'(busy), 64'd0);
        chk("rst:err", 64'(err), 64'd0);
        chk("rst:data_ok", 64'(dresp.data_ok), 64'd0);
        chk("rst:addr_ok", 64'(dresp.addr_ok), 64'd0);
        chk("rst:data", dresp.data, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Known contents for a small window and the top word
        for (int i = 0; i < 16; i++) begin
            txn(BASE + 64'(8 * i), 3'd3, 8'hFF, {$urandom, $urandom}, "init", rd);
        end
        txn(TOP - 64'd8, 3'd3, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, "init_top", rd);

        // Full write then read back
        txn(64'h8000_0010, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, "t1_wr", rd);
        txn(64'h8000_0010, 3'd3, 8'h00, 64'h0, "t1_rd", rd);
        chk("t1_rd_const", rd, 64'h1122_3344_5566_7788);

        // Partial write honours strobe only
        txn(64'h8000_0010, 3'd2, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, "t2_wr", rd);
        txn(64'h8000_0010, 3'd3, 8'h00, 64'h0, "t2_rd", rd);
        chk("t2_rd_const", rd, 64'h1122_3344_BBBB_BBBB);

        // Out-of-range on both sides
        txn(64'h7FFF_FFF8, 3'd3, 8'h00, 64'h0, "t3_lo_rd", rd);
        txn(TOP, 3'd3, 8'hFF, 64'h5555_5555_5555_5555, "t3_hi_wr", rd);
        txn(TOP - 64'd8, 3'd3, 8'h00, 64'h0, "t3_top_rd", rd);
        chk("t3_top_const", rd, 64'hDEAD_BEEF_0BAD_F00D);

        // Reset while a write is in flight
        pre = model_read(64'h8000_0040);
        @(negedge clk);
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h8000_0040;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'hFF;
        dreq.data   = ~pre;
        @(posedge clk);
        #1;
        dreq = '0;
        chk("t5:busy_pre", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5:busy", 64'(busy), 64'd0);
        chk("t5:data_ok", 64'(dresp.data_ok), 64'd0);
        chk("t5:addr_ok", 64'(dresp.addr_ok), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        txn(64'h8000_0040, 3'd3, 8'h00, 64'h0, "t5_rd", rd);
        chk("t5_rd_const", rd, pre);

        // Reset during the response cycle clears dresp at once
        @(negedge clk);
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h8000_0010;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'h00;
        @(posedge clk);
        #1;
        dreq = '0;
        @(posedge clk);
        #1;
        chk("t5b:data_ok_pre", 64'(dresp.data_ok), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("t5b:data_ok", 64'(dresp.data_ok), 64'd0);
        chk("t5b:data", dresp.data, 64'd0);
        chk("t5b:busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Misaligned doubleword store
        pre = model_read(BASE);
        txn(64'h8000_0004, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, "t6_wr", rd);
        txn(BASE, 3'd3, 8'h00, 64'h0, "t6_rd", rd);
`ifdef DBUS_RESP_MISALIGN_CHECK_EN
        chk("t6_rd_const", rd, pre);
`else
        chk("t6_rd_const", rd, 64'h0123_4567_89AB_CDEF);
`endif

        // Random traffic over the window plus occasional out-of-range addresses
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0:       a = BASE - 64'(8 * $urandom_range(1, 4));
                1:       a = TOP + 64'($urandom_range(0, 31));
                default: a = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
            endcase
            st = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            txn(a, 3'($urandom_range(0, 3)), st, {$urandom, $urandom}, "rand", rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
